// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the gen2 register file.
package regfile_pkg;
  localparam int RF_W  = 8;
  localparam int RF_D  = 4;
  localparam int RF_NF = 4;

  typedef enum logic {RF_IDLE, RF_LOAD_PEND} rf_state_e;

  typedef enum logic [1:0] {
    FLG_GE = 2'd0,
    FLG_EQ = 2'd1,
    FLG_LT = 2'd2,
    FLG_OV = 2'd3
  } flag_idx_e;
endpackage

// File: rtl/regfile_gen2_rf_read_mux.sv
// One read port: shift-pair address override, then zero register, bypass, array read.
module rf_read_mux #(
  parameter int W       = 8,
  parameter int D       = 4,
  parameter int PORT    = 0,
  parameter int SHIFT_A = 6,
  parameter int SHIFT_B = 7,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic                     Shift,
  input  logic [D-1:0]             Addr,
  input  logic [(1<<D)-1:0][W-1:0] Regs,
  input  logic                     WrKeep,
  input  logic [D-1:0]             WrAddr,
  input  logic [W-1:0]             DataIn,
  output logic [W-1:0]             DataOut
);
  logic [D-1:0] effAddr;

  // Shift redirects the address only; zero and bypass still apply to the redirected read.
  always_comb begin
    effAddr = Addr;
    if (Shift && PORT == 0) effAddr = D'(SHIFT_A);
    if (Shift && PORT == 1) effAddr = D'(SHIFT_B);
  end

  always_comb begin
    DataOut = Regs[effAddr];
    if (ZERO_R0 != 0 && effAddr == '0)
      DataOut = '0;
    else if (BYPASS != 0 && WrKeep && effAddr == WrAddr)
      DataOut = DataIn;
  end
endmodule

// File: rtl/regfile_gen2.sv
// Register file with NRD read ports, one write port, two-cycle immediate load and flag register.
module regfile_gen2
  import regfile_pkg::*;
#(
  parameter int W       = RF_W,
  parameter int D       = RF_D,
  parameter int NRD     = 2,
  parameter int NF      = RF_NF,
  parameter int SHIFT_A = 6,
  parameter int SHIFT_B = 7,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1,
  parameter int STICKY  = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    WriteEn,
  input  logic                    RegSet,
  input  logic                    Shift,
  input  logic [NRD-1:0][D-1:0]   Raddr,
  input  logic [D-1:0]            Waddr,
  input  logic [W-1:0]            DataIn,
  input  logic                    FlagSetEn,
  input  logic [NF-1:0]           FlagIn,
  output logic [NRD-1:0][W-1:0]   DataOut,
  output logic [NF-1:0]           Flags,
  output logic                    IsLoadingReg,
  output logic                    DbgState
);
  logic [(1<<D)-1:0][W-1:0] regs;
  rf_state_e                state;
  logic [D-1:0]             loadTgt;
  logic                     loadPend;
  logic                     weEff;
  logic                     wrKeep;
  logic [D-1:0]             wAddrEff;

  assign loadPend = (state == RF_LOAD_PEND);
  assign weEff    = !Reset && !Start && (loadPend || WriteEn);
  assign wAddrEff = loadPend ? loadTgt : (Shift ? D'(SHIFT_B) : Waddr);
  // A write to R0 with the zero register enabled is dropped, so it must not bypass either.
  assign wrKeep   = weEff && !(ZERO_R0 != 0 && wAddrEff == '0);

  assign IsLoadingReg = loadPend;
  assign DbgState     = state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs    <= '0;
      state   <= RF_IDLE;
      loadTgt <= '0;
      Flags   <= '0;
    end else begin
      if (wrKeep) regs[wAddrEff] <= DataIn;

      case (state)
        RF_IDLE: begin
          if (RegSet && !Start) begin
            state   <= RF_LOAD_PEND;
            loadTgt <= Raddr[1];
          end
        end
        RF_LOAD_PEND: state <= RF_IDLE;
        default:      state <= RF_IDLE;
      endcase

      if (FlagSetEn)        Flags <= FlagIn;
      else if (STICKY == 0) Flags <= '0;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_mux #(
      .W(W), .D(D), .PORT(i), .SHIFT_A(SHIFT_A), .SHIFT_B(SHIFT_B),
      .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
    ) u_mux (
      .Shift  (Shift),
      .Addr   (Raddr[i]),
      .Regs   (regs),
      .WrKeep (wrKeep),
      .WrAddr (wAddrEff),
      .DataIn (DataIn),
      .DataOut(DataOut[i])
    );
  end
endmodule

// File: tb/tb_regfile_gen2.sv
// Directed bench for regfile_gen2: dut0 uses defaults, dut1 has a zero register and sticky flags.
module tb_regfile_gen2;
  logic            Clk = 1'b0;
  logic            Reset, Start, WriteEn, RegSet, Shift, FlagSetEn;
  logic [1:0][3:0] Raddr;
  logic [3:0]      Waddr;
  logic [7:0]      DataIn;
  logic [3:0]      FlagIn;
  logic [1:0][7:0] dout0, dout1;
  logic [3:0]      flags0, flags1;
  logic            isl0, isl1, dbg0, dbg1;

  typedef struct {
    int         dut;
    int         kind;   // 0 = DataOut[idx], 1 = Flags, 2 = IsLoadingReg
    int         idx;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // clock / reset
  always #5 Clk = ~Clk;

  regfile_gen2 dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .WriteEn(WriteEn), .RegSet(RegSet),
    .Shift(Shift), .Raddr(Raddr), .Waddr(Waddr), .DataIn(DataIn),
    .FlagSetEn(FlagSetEn), .FlagIn(FlagIn), .DataOut(dout0), .Flags(flags0),
    .IsLoadingReg(isl0), .DbgState(dbg0)
  );

  regfile_gen2 #(.ZERO_R0(1), .STICKY(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .WriteEn(WriteEn), .RegSet(RegSet),
    .Shift(Shift), .Raddr(Raddr), .Waddr(Waddr), .DataIn(DataIn),
    .FlagSetEn(FlagSetEn), .FlagIn(FlagIn), .DataOut(dout1), .Flags(flags1),
    .IsLoadingReg(isl1), .DbgState(dbg1)
  );

  // driver tasks
  task automatic idle_inputs();
    Reset = 1'b0; Start = 1'b0; WriteEn = 1'b0; RegSet = 1'b0; Shift = 1'b0;
    FlagSetEn = 1'b0; FlagIn = 4'h0; Raddr = '0; Waddr = 4'h0; DataIn = 8'h00;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    idle_inputs();
  endtask

  task automatic expect_out(input int dut, input int kind, input int idx,
                            input logic [7:0] val, input string name);
    exp_t e;
    e.dut = dut; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_both(input int kind, input int idx, input logic [7:0] val,
                             input string name);
    expect_out(0, kind, idx, val, name);
    expect_out(1, kind, idx, val, name);
  endtask

  // scoreboard monitor: checks whatever the current cycle expects, mid-cycle
  always @(negedge Clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = (e.dut == 0) ? dout0[e.idx] : dout1[e.idx];
        1:       act = (e.dut == 0) ? {4'h0, flags0} : {4'h0, flags1};
        default: act = (e.dut == 0) ? {7'h0, isl0} : {7'h0, isl1};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s dut%0d: got %02h expected %02h", e.name, e.dut, act, e.val);
      end
    end
  end

  initial begin
    idle_inputs();
    Reset = 1'b1;
    step();

    // reset state
    Raddr[0] = 4'd3; Raddr[1] = 4'd1;
    expect_both(0, 0, 8'h00, "rst_dout0");
    expect_both(0, 1, 8'h00, "rst_dout1");
    expect_both(1, 0, 8'h00, "rst_flags");
    expect_both(2, 0, 8'h00, "rst_isload");
    step();

    // normal write with same-cycle bypass, then registered read
    WriteEn = 1'b1; Waddr = 4'd3; DataIn = 8'hA5; Raddr[0] = 4'd3;
    expect_both(0, 0, 8'hA5, "wr_bypass");
    step();
    Raddr[0] = 4'd3;
    expect_both(0, 0, 8'hA5, "wr_r3");
    step();

    // immediate load into R5
    RegSet = 1'b1; Raddr[1] = 4'd5;
    expect_both(2, 0, 8'h00, "ld_idle");
    step();
    DataIn = 8'h3C; Raddr[0] = 4'd5; Raddr[1] = 4'd5;
    expect_both(2, 0, 8'h01, "ld_pend");
    expect_both(0, 1, 8'h3C, "ld_bypass");
    step();
    Raddr[0] = 4'd5;
    expect_both(0, 0, 8'h3C, "ld_r5");
    expect_both(2, 0, 8'h00, "ld_done");
    step();

    // load into R9 aborted by Start
    RegSet = 1'b1; Raddr[1] = 4'd9;
    step();
    Start = 1'b1; DataIn = 8'hFF; Raddr[0] = 4'd9;
    expect_both(2, 0, 8'h01, "abort_pend");
    expect_both(0, 0, 8'h00, "abort_nobyp");
    step();
    Raddr[0] = 4'd9;
    expect_both(0, 0, 8'h00, "abort_r9");
    expect_both(2, 0, 8'h00, "abort_idle");
    step();

    // shift pair
    WriteEn = 1'b1; Waddr = 4'd6; DataIn = 8'h11;
    step();
    WriteEn = 1'b1; Waddr = 4'd7; DataIn = 8'h22;
    step();
    Shift = 1'b1; WriteEn = 1'b1; Waddr = 4'd2; DataIn = 8'h44; Raddr[0] = 4'd2; Raddr[1] = 4'd2;
    expect_both(0, 0, 8'h11, "shift_a");
    expect_both(0, 1, 8'h44, "shift_b_byp");
    step();
    Raddr[0] = 4'd7; Raddr[1] = 4'd2;
    expect_both(0, 0, 8'h44, "shift_r7");
    expect_both(0, 1, 8'h00, "shift_r2");
    step();

    // R0: ordinary register on dut0, hardwired zero on dut1
    WriteEn = 1'b1; Waddr = 4'd0; DataIn = 8'h77;
    expect_out(0, 0, 0, 8'h77, "r0_byp");
    expect_out(1, 0, 0, 8'h00, "r0_zero_byp");
    step();
    expect_out(0, 0, 0, 8'h77, "r0_rd");
    expect_out(1, 0, 0, 8'h00, "r0_zero_rd");
    step();
    RegSet = 1'b1; Raddr[1] = 4'd0;
    step();
    DataIn = 8'h5A;
    expect_both(2, 0, 8'h01, "r0ld_pend");
    expect_out(1, 0, 0, 8'h00, "r0ld_zero_byp");
    step();
    expect_out(0, 0, 0, 8'h5A, "r0ld_rd");
    expect_out(1, 0, 0, 8'h00, "r0ld_zero_rd");
    expect_both(2, 0, 8'h00, "r0ld_idle");
    step();

    // flags: pulse on dut0, sticky on dut1, independent of Start
    FlagSetEn = 1'b1; FlagIn = 4'b0001; Start = 1'b1;
    step();
    expect_both(1, 0, 8'h01, "flg_set");
    step();
    expect_out(0, 1, 0, 8'h00, "flg_pulse_clr");
    expect_out(1, 1, 0, 8'h01, "flg_sticky_hold");
    step();
    Reset = 1'b1;
    step();
    Raddr[0] = 4'd5;
    expect_out(1, 1, 0, 8'h00, "flg_sticky_rst");
    expect_both(0, 0, 8'h00, "rst_clears_r5");
    step();

    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
